fadd_sub_pipe: RTL and testbench

Pipelined, parametrised floating-point add/subtract core. It performs the add/sub of pre-aligned mantissas, normalises the result, and extracts guard/round/sticky, all behind a valid/ready handshake. It sits between the FP operand extract/align stage and the rounding/packing stage of the FPU. It is the successor of the single-cycle combinational mantissa adder: widths are generalised, and it adds an explicit subtract op, normalisation, zero detection and stall-capable pipelining.

---
 rtl/fadd_sub_pipe.sv | 190 +++++++++++++++++++
 tb/tb_fadd_sub_pipe.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/fadd_sub_pipe.sv
// Three-stage FP mantissa add/sub core: add/sub, normalise, guard/round/sticky extract.
// Optional `FADD_PIPE_STATUS_EN adds out_ovf/out_unf exponent status flags.
module fadd_sub_pipe #(
   parameter int unsigned MANT_W = 24,
   parameter int unsigned EXP_W  = 8
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic                  sign1,
   input  logic                  sign2,
   input  logic                  op_sub,
   input  logic [EXP_W-1:0]      exp_common,
   input  logic [2*MANT_W-1:0]   mantissa1_aligned,
   input  logic [2*MANT_W-1:0]   mantissa2_aligned,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic                  out_sign,
   output logic [EXP_W-1:0]      out_exp,
   output logic [MANT_W-1:0]     out_mant,
   output logic [2:0]            out_grs,
`ifdef FADD_PIPE_STATUS_EN
   output logic                  out_ovf,
   output logic                  out_unf,
`endif
   output logic                  out_zero
);

   localparam int unsigned AL_W  = 2 * MANT_W;
   localparam int unsigned SUM_W = AL_W + 1;
   localparam int unsigned LZ_W  = $clog2(AL_W + 1);

   logic en1, en2, en3;
   logic v1, v2;

   // Stall chain: a stage advances when it is empty or the next one advances.
   assign en3      = !out_valid | out_ready;
   assign en2      = !v2 | en3;
   assign en1      = !v1 | en2;
   assign in_ready = en1;

   // S1: effective-sign add, or larger-minus-smaller magnitude subtract
   logic               s2e;
   logic [SUM_W-1:0]   m1_x, m2_x, sum_d;
   logic               sign_d;
   logic               zero_d;

   always_comb begin
      s2e    = sign2 ^ op_sub;
      m1_x   = {1'b0, mantissa1_aligned};
      m2_x   = {1'b0, mantissa2_aligned};
      sum_d  = '0;
      sign_d = 1'b0;
      if (sign1 == s2e) begin
         sum_d  = m1_x + m2_x;
         sign_d = sign1;
      end else if (m1_x > m2_x) begin
         sum_d  = m1_x - m2_x;
         sign_d = sign1;
      end else if (m2_x > m1_x) begin
         sum_d  = m2_x - m1_x;
         sign_d = s2e;
      end
      zero_d = (sum_d == '0);
   end

   logic [SUM_W-1:0]   s1_sum;
   logic               s1_sign;
   logic [EXP_W-1:0]   s1_exp;
   logic               s1_zero;

   always_ff @(posedge clk) begin
      if (reset) begin
         v1      <= 1'b0;
         s1_sum  <= '0;
         s1_sign <= 1'b0;
         s1_exp  <= '0;
         s1_zero <= 1'b0;
      end else if (en1) begin
         v1 <= in_valid;
         if (in_valid) begin
            s1_sum  <= sum_d;
            s1_sign <= sign_d;
            s1_exp  <= exp_common;
            s1_zero <= zero_d;
         end
      end
   end

   // S2: normalise on carry-out or by leading-zero count
   logic [LZ_W-1:0]    lz;
   logic [AL_W-1:0]    norm_d;
   logic               sx_d;
   logic [EXP_W-1:0]   exp_inc;
   logic [EXP_W-1:0]   nexp_d;
   logic               lz_unf;

   always_comb begin
      lz = LZ_W'(AL_W);
      for (int i = 0; i < int'(AL_W); i++) begin
         if (s1_sum[i]) lz = LZ_W'(int'(AL_W) - 1 - i);
      end
      exp_inc = s1_exp + EXP_W'(1);
      lz_unf  = (32'(lz) >= 32'(s1_exp));
      norm_d  = '0;
      sx_d    = 1'b0;
      nexp_d  = '0;
      if (s1_sum[SUM_W-1]) begin
         norm_d = s1_sum[SUM_W-1:1];
         sx_d   = s1_sum[0];
         nexp_d = exp_inc;
      end else if (!s1_zero) begin
         norm_d = s1_sum[AL_W-1:0] << lz;
         if (!lz_unf) nexp_d = s1_exp - EXP_W'(lz);
      end
   end

`ifdef FADD_PIPE_STATUS_EN
   logic ovf_d, unf_d;
   logic s2_ovf, s2_unf;
   assign ovf_d = s1_sum[SUM_W-1] && (exp_inc == '1);
   assign unf_d = !s1_sum[SUM_W-1] && !s1_zero && lz_unf;
`endif

   logic [AL_W-1:0]    s2_norm;
   logic               s2_sx;
   logic               s2_sign;
   logic [EXP_W-1:0]   s2_exp;
   logic               s2_zero;

   always_ff @(posedge clk) begin
      if (reset) begin
         v2      <= 1'b0;
         s2_norm <= '0;
         s2_sx   <= 1'b0;
         s2_sign <= 1'b0;
         s2_exp  <= '0;
         s2_zero <= 1'b0;
`ifdef FADD_PIPE_STATUS_EN
         s2_ovf  <= 1'b0;
         s2_unf  <= 1'b0;
`endif
      end else if (en2) begin
         v2 <= v1;
         if (v1) begin
            s2_norm <= norm_d;
            s2_sx   <= sx_d;
            s2_sign <= s1_sign;
            s2_exp  <= nexp_d;
            s2_zero <= s1_zero;
`ifdef FADD_PIPE_STATUS_EN
            s2_ovf  <= ovf_d;
            s2_unf  <= unf_d;
`endif
         end
      end
   end

   // S3: mantissa, guard/round/sticky extraction into the output registers
   always_ff @(posedge clk) begin
      if (reset) begin
         out_valid <= 1'b0;
         out_sign  <= 1'b0;
         out_exp   <= '0;
         out_mant  <= '0;
         out_grs   <= '0;
         out_zero  <= 1'b0;
`ifdef FADD_PIPE_STATUS_EN
         out_ovf   <= 1'b0;
         out_unf   <= 1'b0;
`endif
      end else if (en3) begin
         out_valid <= v2;
         if (v2) begin
            out_sign <= s2_sign;
            out_exp  <= s2_exp;
            out_mant <= s2_norm[AL_W-1:MANT_W];
            out_grs  <= {s2_norm[MANT_W-1], s2_norm[MANT_W-2],
                         (|s2_norm[MANT_W-3:0]) | s2_sx};
            out_zero <= s2_zero;
`ifdef FADD_PIPE_STATUS_EN
            out_ovf  <= s2_ovf;
            out_unf  <= s2_unf;
`endif
         end
      end
   end

endmodule

// File: tb/tb_fadd_sub_pipe.sv
// Directed bench for fadd_sub_pipe: arithmetic vectors, backpressure, reset flush, overflow.
module tb_fadd_sub_pipe;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic          sign1 = 1'b0, sign2 = 1'b0, op_sub = 1'b0;
   logic [7:0]    exp_common = '0;
   logic [47:0]   mantissa1_aligned = '0, mantissa2_aligned = '0;
   logic          out_valid;
   logic          out_ready = 1'b1;
   logic          out_sign;
   logic [7:0]    out_exp;
   logic [23:0]   out_mant;
   logic [2:0]    out_grs;
   logic          out_zero;
`ifdef FADD_PIPE_STATUS_EN
   logic          out_ovf, out_unf;
`endif

   int vectors = 0;
   int miscompares = 0;

   fadd_sub_pipe #(.MANT_W(24), .EXP_W(8)) dut (
      .clk(clk), .reset(reset),
      .in_valid(in_valid), .in_ready(in_ready),
      .sign1(sign1), .sign2(sign2), .op_sub(op_sub),
      .exp_common(exp_common),
      .mantissa1_aligned(mantissa1_aligned), .mantissa2_aligned(mantissa2_aligned),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_sign(out_sign), .out_exp(out_exp), .out_mant(out_mant),
      .out_grs(out_grs),
`ifdef FADD_PIPE_STATUS_EN
      .out_ovf(out_ovf), .out_unf(out_unf),
`endif
      .out_zero(out_zero)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      vectors++;
      assert (got === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic s1, input logic s2, input logic sub, input logic [7:0] e,
                        input logic [47:0] a, input logic [47:0] b);
      sign1 = s1; sign2 = s2; op_sub = sub; exp_common = e;
      mantissa1_aligned = a; mantissa2_aligned = b;
      in_valid = 1'b1;
   endtask

   // One bundle through an idle pipe; checks latency and every result field.
   task automatic run_one(input string tag, input logic s1, input logic s2, input logic sub,
                          input logic [7:0] e, input logic [47:0] a, input logic [47:0] b,
                          input logic es, input logic [7:0] ee, input logic [23:0] em,
                          input logic [2:0] eg, input logic ez);
      drive(s1, s2, sub, e, a, b);
      chk({tag, "_in_ready"}, 64'(in_ready), 64'd1);
      tick;
      in_valid = 1'b0;
      tick;
      chk({tag, "_early"}, 64'(out_valid), 64'd0);
      tick;
      chk({tag, "_valid"}, 64'(out_valid), 64'd1);
      chk({tag, "_sign"},  64'(out_sign),  64'(es));
      chk({tag, "_exp"},   64'(out_exp),   64'(ee));
      chk({tag, "_mant"},  64'(out_mant),  64'(em));
      chk({tag, "_grs"},   64'(out_grs),   64'(eg));
      chk({tag, "_zero"},  64'(out_zero),  64'(ez));
   endtask

   logic [7:0] got_exp [8];
   logic [7:0] bp_exp  [4];
   int         n;

   initial begin
      #100000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      bp_exp = '{8'd11, 8'd21, 8'd31, 8'd41};
      tick;
      tick;
      reset = 1'b0;
      chk("rst_valid", 64'(out_valid), 64'd0);
      chk("rst_ready", 64'(in_ready), 64'd1);
      chk("rst_sign",  64'(out_sign), 64'd0);
      chk("rst_exp",   64'(out_exp),  64'd0);
      chk("rst_mant",  64'(out_mant), 64'd0);
      chk("rst_grs",   64'(out_grs),  64'd0);
      chk("rst_zero",  64'(out_zero), 64'd0);
`ifdef FADD_PIPE_STATUS_EN
      chk("rst_ovf",   64'(out_ovf),  64'd0);
      chk("rst_unf",   64'(out_unf),  64'd0);
`endif

      run_one("one_plus_one", 0, 0, 0, 8'd127, 48'h800000_000000, 48'h800000_000000,
              0, 8'd128, 24'h800000, 3'b000, 0);
      run_one("onehalf_minus_one", 0, 0, 1, 8'd127, 48'hC00000_000000, 48'h800000_000000,
              0, 8'd126, 24'h800000, 3'b000, 0);
      run_one("equal_sub", 1, 1, 1, 8'd127, 48'hA00000_000000, 48'hA00000_000000,
              0, 8'd0, 24'h000000, 3'b000, 1);
      run_one("carry_sticky", 0, 0, 0, 8'd100, 48'hFFFFFF_000001, 48'h800000_000000,
              0, 8'd101, 24'hBFFFFF, 3'b101, 0);
      run_one("neg_result", 0, 0, 1, 8'd127, 48'h800000_000000, 48'hC00000_000000,
              1, 8'd126, 24'h800000, 3'b000, 0);
      run_one("sub_of_neg", 0, 1, 1, 8'd127, 48'h800000_000000, 48'h800000_000000,
              0, 8'd128, 24'h800000, 3'b000, 0);
      run_one("round_bit", 1, 1, 0, 8'd60, 48'h800000_400000, 48'h000000_000000,
              1, 8'd60, 24'h800000, 3'b010, 0);
      run_one("underflow", 0, 0, 1, 8'd2, 48'h800000_000000, 48'h7FFFFF_000000,
              0, 8'd0, 24'h800000, 3'b000, 0);
`ifdef FADD_PIPE_STATUS_EN
      chk("underflow_unf", 64'(out_unf), 64'd1);
      chk("underflow_ovf", 64'(out_ovf), 64'd0);
`endif
      run_one("overflow", 0, 0, 0, 8'd254, 48'h800000_000000, 48'h800000_000000,
              0, 8'd255, 24'h800000, 3'b000, 0);
`ifdef FADD_PIPE_STATUS_EN
      chk("overflow_ovf", 64'(out_ovf), 64'd1);
      chk("overflow_unf", 64'(out_unf), 64'd0);
`endif

      // Backpressure: drain, then offer four bundles with out_ready held low.
      tick;
      out_ready = 1'b0;
      drive(0, 0, 0, 8'd10, 48'h800000_000000, 48'h800000_000000);
      #1;
      chk("bp_acc_a", 64'(in_ready), 64'd1);
      tick;
      drive(0, 0, 0, 8'd20, 48'h800000_000000, 48'h800000_000000);
      chk("bp_acc_b", 64'(in_ready), 64'd1);
      tick;
      drive(0, 0, 0, 8'd30, 48'h800000_000000, 48'h800000_000000);
      chk("bp_acc_c", 64'(in_ready), 64'd1);
      tick;
      drive(0, 0, 0, 8'd40, 48'h800000_000000, 48'h800000_000000);
      chk("bp_full_ready", 64'(in_ready), 64'd0);
      chk("bp_head_valid", 64'(out_valid), 64'd1);
      chk("bp_head_exp", 64'(out_exp), 64'd11);
      tick;
      chk("bp_hold_ready", 64'(in_ready), 64'd0);
      chk("bp_hold_exp", 64'(out_exp), 64'd11);
      tick;
      out_ready = 1'b1;
      #1;
      chk("bp_release_ready", 64'(in_ready), 64'd1);
      n = 0;
      for (int k = 0; k < 8; k++) begin
         if (out_valid && n < 8) begin
            got_exp[n] = out_exp;
            n++;
         end
         tick;
         in_valid = 1'b0;
      end
      chk("bp_count", 64'(n), 64'd4);
      for (int k = 0; k < 4; k++) begin
         chk($sformatf("bp_order_%0d", k), 64'(got_exp[k]), 64'(bp_exp[k]));
      end

      // Reset with two bundles in flight: neither may emerge.
      drive(0, 0, 0, 8'd70, 48'h800000_000000, 48'h800000_000000);
      tick;
      drive(0, 0, 0, 8'd80, 48'h800000_000000, 48'h800000_000000);
      tick;
      in_valid = 1'b0;
      reset = 1'b1;
      tick;
      reset = 1'b0;
      chk("flush_valid", 64'(out_valid), 64'd0);
      chk("flush_ready", 64'(in_ready), 64'd1);
      for (int k = 0; k < 4; k++) begin
         tick;
         chk($sformatf("flush_quiet_%0d", k), 64'(out_valid), 64'd0);
      end
      run_one("post_flush", 0, 0, 0, 8'd50, 48'h800000_000000, 48'h800000_000000,
              0, 8'd51, 24'h800000, 3'b000, 0);

      tick;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
